// File: rtl/alu_pkg.sv
// Shared definitions for the picoMIPS ALU: function-select codes used by the
// decoder, the ALU itself and any bench driving it.
package alu_pkg;

  typedef enum logic {
    RADD = 1'b0,
    RMUL = 1'b1
  } func_e;

  localparam int ALU_N_DEFAULT = 8;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the register-file read ports and the ALU.
// The master drives operands and func; the slave (the ALU) returns result.
interface alu_if #(
  parameter int n = alu_pkg::ALU_N_DEFAULT
);
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         func;
  logic [n-1:0] result;

  modport master (output a, output b, output func, input result);
  modport slave  (input a, input b, input func, output result);
endinterface

// File: rtl/alu_mul.sv
// Combinational n x n multiplier keeping only the low n bits of the product;
// these bits are the same for signed and unsigned operands.
module alu_mul #(
  parameter int n = 8
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/alu.sv
// picoMIPS ALU: add or multiply two n-bit operands, result registered one
// clock later; synchronous active-high reset clears the result.
import alu_pkg::*;

module alu #(
  parameter int n = ALU_N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  logic [n-1:0] sum;
  logic [n-1:0] prod;
  logic [n-1:0] result_d;
  logic [n-1:0] result_q;

  // Carry out of the adder is intentionally dropped: result wraps mod 2^n.
  assign sum = bus.a + bus.b;

  alu_mul #(.n(n)) u_mul (
    .a_i (bus.a),
    .b_i (bus.b),
    .p_o (prod)
  );

  always_comb begin
    result_d = sum;
    if (func_e'(bus.func) == RMUL) result_d = prod;
  end

  always_ff @(posedge clk) begin
    if (reset) result_q <= '0;
    else       result_q <= result_d;
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the ALU against a plain-arithmetic model.
import alu_pkg::*;

module tb_alu;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  alu_if #(.n(8)) bus ();

  alu #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic f);
    int unsigned r;
    if (f) r = (int'(a) * int'(b)) % 256;
    else   r = (int'(a) + int'(b)) % 256;
    return r[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic f);
    bus.a    = a;
    bus.b    = b;
    bus.func = f;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rf;
    compared   = 0;
    mismatched = 0;

    // Reset with live operands on the bus.
    reset = 1'b1;
    drive(8'h7A, 8'h08, RADD);
    tick();
    chk("reset", bus.result, 8'h00);
    tick();
    chk("reset_hold", bus.result, 8'h00);

    reset = 1'b0;
    drive(8'h7A, 8'h08, RADD);
    tick();
    chk("add_7A_08", bus.result, 8'h82);

    drive(8'h7A, 8'h08, RMUL);
    tick();
    chk("mul_7A_08", bus.result, 8'hD0);

    drive(8'hFF, 8'h01, RADD);
    tick();
    chk("add_wrap", bus.result, 8'h00);

    drive(8'hFF, 8'hFF, RMUL);
    tick();
    chk("mul_FF_FF", bus.result, 8'h01);

    drive(8'h10, 8'h10, RMUL);
    tick();
    chk("mul_10_10", bus.result, 8'h00);

    drive(8'h00, 8'h5A, RMUL);
    tick();
    chk("mul_zero", bus.result, 8'h00);

    // func change between edges must not reach result until the next edge.
    drive(8'h7A, 8'h08, RADD);
    tick();
    chk("lat_add", bus.result, 8'h82);
    bus.func = RMUL;
    #3;
    chk("lat_hold", bus.result, 8'h82);
    tick();
    chk("lat_mul", bus.result, 8'hD0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rf = 1'($urandom_range(0, 1));
      drive(ra, rb, rf);
      if (i == 500) begin
        reset = 1'b1;
        tick();
        chk("rand_reset", bus.result, 8'h00);
        reset = 1'b0;
      end else begin
        tick();
        chk(rf ? "rand_mul" : "rand_add", bus.result, model(ra, rb, rf));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
